// File: rtl/decode_cycle.sv
// RV32I decode stage: register file with write-through bypass, main/ALU decoders,
// immediate generation and the D/E pipeline register feeding execute.
module decode_cycle #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       InstrD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RDW,
    input  logic [XLEN-1:0]   ResultW,
    input  logic              FlushE,
    output logic              RegWriteE,
    output logic [1:0]        ResultSrcE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic [2:0]        ALUControlE,
    output logic              ALUSrcE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic              IllegalE
);

    localparam int NREGS = 1 << REG_AW;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immSrcT;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluOpT;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } aluCtlT;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]        opcodeD;
    logic [2:0]        funct3D;
    logic              funct7b5D;
    logic [REG_AW-1:0] rs1D;
    logic [REG_AW-1:0] rs2D;
    logic [REG_AW-1:0] rdD;

    assign opcodeD   = InstrD[6:0];
    assign funct3D   = InstrD[14:12];
    assign funct7b5D = InstrD[30];
    assign rs1D      = InstrD[19:15];
    assign rs2D      = InstrD[24:20];
    assign rdD       = InstrD[11:7];

    // ------------------------------------------------------------------
    // Register file: x0 has no storage, x1..x31 cleared by reset
    // ------------------------------------------------------------------
    logic              wrEnW;
    logic [XLEN-1:0]   regWord [NREGS];

    assign wrEnW = RegWriteW && (RDW != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : gRegs
            if (gi == 0) begin : gZero
                assign regWord[gi] = '0;
            end else begin : gStore
                logic [XLEN-1:0] regQ;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        regQ <= '0;
                    end else if (wrEnW && (RDW == REG_AW'(gi))) begin
                        regQ <= ResultW;
                    end
                end

                assign regWord[gi] = regQ;
            end
        end
    endgenerate

    // A write landing this cycle is visible to the instruction decoding now
    logic [XLEN-1:0] rd1D;
    logic [XLEN-1:0] rd2D;

    always_comb begin
        if (rs1D == '0) begin
            rd1D = '0;
        end else if (wrEnW && (RDW == rs1D)) begin
            rd1D = ResultW;
        end else begin
            rd1D = regWord[rs1D];
        end

        if (rs2D == '0) begin
            rd2D = '0;
        end else if (wrEnW && (RDW == rs2D)) begin
            rd2D = ResultW;
        end else begin
            rd2D = regWord[rs2D];
        end
    end

    // ------------------------------------------------------------------
    // Main decoder
    // ------------------------------------------------------------------
    logic       regWriteD;
    immSrcT     immSrcD;
    logic       immValidD;
    logic       aluSrcD;
    logic       memWriteD;
    logic [1:0] resultSrcD;
    logic       branchD;
    aluOpT      aluOpD;
    logic       jumpD;
    logic       illegalD;

    always_comb begin
        regWriteD  = 1'b0;
        immSrcD    = IMM_I;
        immValidD  = 1'b0;
        aluSrcD    = 1'b0;
        memWriteD  = 1'b0;
        resultSrcD = RES_ALU;
        branchD    = 1'b0;
        aluOpD     = ALUOP_ADD;
        jumpD      = 1'b0;
        illegalD   = 1'b0;

        case (opcodeD)
            OP_LOAD: begin
                regWriteD  = 1'b1;
                immSrcD    = IMM_I;
                immValidD  = 1'b1;
                aluSrcD    = 1'b1;
                resultSrcD = RES_MEM;
            end
            OP_STORE: begin
                immSrcD    = IMM_S;
                immValidD  = 1'b1;
                aluSrcD    = 1'b1;
                memWriteD  = 1'b1;
            end
            OP_RTYPE: begin
                regWriteD  = 1'b1;
                aluOpD     = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                immSrcD    = IMM_B;
                immValidD  = 1'b1;
                branchD    = 1'b1;
                aluOpD     = ALUOP_SUB;
            end
            OP_ITYPE: begin
                regWriteD  = 1'b1;
                immSrcD    = IMM_I;
                immValidD  = 1'b1;
                aluSrcD    = 1'b1;
                aluOpD     = ALUOP_FUNCT;
            end
            OP_JAL: begin
                regWriteD  = 1'b1;
                immSrcD    = IMM_J;
                immValidD  = 1'b1;
                resultSrcD = RES_PC4;
                jumpD      = 1'b1;
            end
            default: begin
                illegalD   = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ALU decoder: subtract only for R-type with funct7[5] set (addi has no sub)
    // ------------------------------------------------------------------
    aluCtlT aluControlD;

    always_comb begin
        aluControlD = ALU_ADD;
        case (aluOpD)
            ALUOP_ADD: aluControlD = ALU_ADD;
            ALUOP_SUB: aluControlD = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3D)
                    3'b000:  aluControlD = (opcodeD[5] && funct7b5D) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluControlD = ALU_SLT;
                    3'b110:  aluControlD = ALU_OR;
                    3'b111:  aluControlD = ALU_AND;
                    default: aluControlD = ALU_ADD;
                endcase
            end
            default: aluControlD = ALU_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // Immediate generation
    // ------------------------------------------------------------------
    logic [XLEN-1:0] immExtD;

    always_comb begin
        immExtD = '0;
        if (immValidD) begin
            case (immSrcD)
                IMM_I: immExtD = {{20{InstrD[31]}}, InstrD[31:20]};
                IMM_S: immExtD = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
                IMM_B: immExtD = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                                  InstrD[11:8], 1'b0};
                IMM_J: immExtD = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20],
                                  InstrD[30:21], 1'b0};
                default: immExtD = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // D/E pipeline register; reset and flush both produce a bubble
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            RegWriteE   <= 1'b0;
            ResultSrcE  <= '0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= '0;
            ALUSrcE     <= 1'b0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
            IllegalE    <= 1'b0;
        end else begin
            RegWriteE   <= regWriteD;
            ResultSrcE  <= resultSrcD;
            MemWriteE   <= memWriteD;
            JumpE       <= jumpD;
            BranchE     <= branchD;
            ALUControlE <= aluControlD;
            ALUSrcE     <= aluSrcD;
            RD1E        <= rd1D;
            RD2E        <= rd2D;
            ImmExtE     <= immExtD;
            Rs1E        <= rs1D;
            Rs2E        <= rs2D;
            RdE         <= rdD;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
            IllegalE    <= illegalD;
        end
    end

endmodule
